// File: rtl/psg_bus_responder_if.sv
// Bus-side pins of the YM2149/AY-3-8910 register interface (BC2 tied high).
interface psg_bus_responder_if;
    logic       I_BDIR;
    logic       I_BC1;
    logic [7:0] I_DI;
    logic [7:0] O_DO;
    logic       O_DO_oe;

    modport master (output I_BDIR, output I_BC1, output I_DI, input O_DO, input O_DO_oe);
    modport slave  (input I_BDIR, input I_BC1, input I_DI, output O_DO, output O_DO_oe);
endinterface

// File: rtl/psg_bus_responder.sv
// PSG register-file responder: synchronizes and debounces the async BDIR/BC1/DI
// bus, decodes address/write/read commands and holds the 16 masked registers.
module psg_bus_responder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [3:0]  CHIP_ADDR     = 4'h0
) (
    input  logic                  I_clk_audio,
    input  logic                  I_reset_n,
    psg_bus_responder_if.slave    bus,
    output logic                  O_wr_stb,
    output logic [3:0]            O_wr_addr,
    output logic [7:0]            O_wr_data,
    output logic                  O_env_restart,
    output logic [127:0]          O_regs
);

    typedef enum logic [1:0] {
        CMD_INACTIVE = 2'b00,
        CMD_READ     = 2'b01,
        CMD_WRITE    = 2'b10,
        CMD_ADDRESS  = 2'b11
    } cmd_e;

    localparam logic [3:0] CNT_STABLE = 4'(STABLE_CYCLES - 1);

    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        logic [7:0] m;
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13:   m = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:   m = 8'h1F;
            default:                   m = 8'hFF;
        endcase
        return m;
    endfunction

    logic [9:0]       sync1_q, sync1_d;
    logic [9:0]       sync2_q, sync2_d;
    logic [9:0]       prev_q, prev_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [9:0]       last_q, last_d;
    logic [3:0]       addr_q, addr_d;
    logic             selected_q, selected_d;
    logic [15:0][7:0] regs_q, regs_d;
    logic             do_oe_q, do_oe_d;
    logic             wr_stb_q, wr_stb_d;
    logic [3:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             env_q, env_d;

    logic             same;
    logic             accept;
    cmd_e             cmd;
    logic [7:0]       di;
    logic [7:0]       masked;

    always_comb begin
        sync1_d    = {bus.I_BDIR, bus.I_BC1, bus.I_DI};
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        cmd        = cmd_e'(sync2_q[9:8]);
        di         = sync2_q[7:0];
        masked     = di & reg_mask(addr_q);
        same       = (sync2_q == prev_q);

        // Counter saturates at the threshold; the last-tuple compare keeps a
        // held tuple from being accepted again on every following cycle.
        cnt_d = 4'd0;
        if (same) cnt_d = (cnt_q == CNT_STABLE) ? cnt_q : cnt_q + 4'd1;
        accept = same && (cnt_q == CNT_STABLE) && (sync2_q != last_q);

        last_d     = last_q;
        addr_d     = addr_q;
        selected_d = selected_q;
        regs_d     = regs_q;
        wr_stb_d   = 1'b0;
        env_d      = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        do_oe_d    = (cmd == CMD_READ) ? do_oe_q : 1'b0;

        if (accept) begin
            last_d = sync2_q;
            case (cmd)
                CMD_ADDRESS: begin
                    if (di[7:4] == CHIP_ADDR) begin
                        addr_d     = di[3:0];
                        selected_d = 1'b1;
                    end else begin
                        selected_d = 1'b0;
                    end
                end
                CMD_WRITE: begin
                    if (selected_q) begin
                        regs_d[addr_q] = masked;
                        wr_stb_d       = 1'b1;
                        wr_addr_d      = addr_q;
                        wr_data_d      = masked;
                        env_d          = (addr_q == 4'd13);
                    end
                end
                CMD_READ: begin
                    if (selected_q) do_oe_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk_audio) begin
        if (!I_reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            last_q     <= {CMD_INACTIVE, 8'h00};
            addr_q     <= '0;
            selected_q <= 1'b1;
            regs_q     <= '0;
            do_oe_q    <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            env_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            selected_q <= selected_d;
            regs_q     <= regs_d;
            do_oe_q    <= do_oe_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            env_q      <= env_d;
        end
    end

    assign bus.O_DO    = regs_q[addr_q];
    assign bus.O_DO_oe = do_oe_q;
    assign O_wr_stb      = wr_stb_q;
    assign O_wr_addr     = wr_addr_q;
    assign O_wr_data     = wr_data_q;
    assign O_env_restart = env_q;
    assign O_regs        = regs_q;

endmodule

// File: tb/tb_psg_bus_responder.sv
// Directed bench for psg_bus_responder: stimulus pushes expected writes into a
// queue, a negedge monitor pops and checks each strobe.
module tb_psg_bus_responder;

    localparam int unsigned STABLE = 4;
    localparam int LAT = STABLE + 3;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       env;
        int         cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         wr_stb;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         env_restart;
    logic [127:0] regs;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    psg_bus_responder_if bus();

    psg_bus_responder #(
        .STABLE_CYCLES(STABLE),
        .CHIP_ADDR    (4'h0)
    ) dut (
        .I_clk_audio  (clk),
        .I_reset_n    (reset_n),
        .bus          (bus),
        .O_wr_stb     (wr_stb),
        .O_wr_addr    (wr_addr),
        .O_wr_data    (wr_data),
        .O_env_restart(env_restart),
        .O_regs       (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [7:0] di, input int hold);
        bus.I_BDIR = cmd[1];
        bus.I_BC1  = cmd[0];
        bus.I_DI   = di;
        wait_cyc(hold);
    endtask

    function automatic logic [7:0] reg_of(input int n);
        logic [127:0] r;
        r = regs;
        return r[8*n +: 8];
    endfunction

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] masked, input int hold);
        exp_t e;
        drive(2'b11, a, hold);
        drive(2'b00, 8'h00, hold);
        e.addr = a[3:0]; e.data = masked; e.env = (a[3:0] == 4'd13); e.cyc = cyc + LAT;
        exp_q.push_back(e);
        drive(2'b10, d, hold);
        drive(2'b00, 8'h00, hold);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (env_restart && !wr_stb) check("env_without_stb", 1, 0);
            if (wr_stb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_stb", {wr_addr, wr_data}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("env_restart", env_restart, e.env);
                    check("wr_cycle", cyc, e.cyc);
                    check("reg_after_wr", reg_of(int'(e.addr)), e.data);
                end
            end
        end
    end

    initial begin
        logic [127:0] snap;
        exp_t e;
        int   drop;

        reset_n = 1'b0;
        bus.I_BDIR = 1'b0; bus.I_BC1 = 1'b0; bus.I_DI = 8'h00;
        wait_cyc(3);
        check("rst_regs", regs, '0);
        check("rst_do", bus.O_DO, 0);
        check("rst_do_oe", bus.O_DO_oe, 0);
        check("rst_outs", {wr_stb, wr_addr, wr_data, env_restart}, 0);
        reset_n = 1'b1;
        wait_cyc(5);

        reg_write(8'h00, 8'hAC, 8'hAC, 100);
        check("r0", reg_of(0), 8'hAC);
        check("wr_data_held", wr_data, 8'hAC);

        reg_write(8'h01, 8'hFF, 8'h0F, 20);
        check("r1_mask", reg_of(1), 8'h0F);
        reg_write(8'h08, 8'hFF, 8'h1F, 20);
        check("r8_mask", reg_of(8), 8'h1F);
        reg_write(8'h07, 8'hA5, 8'hA5, 20);

        reg_write(8'h0D, 8'h09, 8'h09, 20);
        check("r13", reg_of(13), 8'h09);

        snap = regs;
        drive(2'b11, 8'h17, 20);
        drive(2'b00, 8'h00, 20);
        drive(2'b10, 8'h55, 20);
        drive(2'b00, 8'h00, 20);
        check("desel_regs", regs, snap);
        drive(2'b01, 8'h00, 20);
        check("desel_read_oe", bus.O_DO_oe, 0);
        drive(2'b00, 8'h00, 20);
        drive(2'b11, 8'h07, 20);
        drive(2'b00, 8'h00, 20);
        drive(2'b01, 8'h00, 20);
        check("read_oe", bus.O_DO_oe, 1);
        check("read_do", bus.O_DO, 8'hA5);
        bus.I_BDIR = 1'b0; bus.I_BC1 = 1'b0;
        drop = 0;
        while (bus.O_DO_oe === 1'b1 && drop < 3) begin
            wait_cyc(1);
            drop++;
        end
        check("oe_drop_within_3", bus.O_DO_oe, 0);
        wait_cyc(20);

        drive(2'b11, 8'h02, 20);
        drive(2'b00, 8'h00, 20);
        drive(2'b10, 8'h3C, 2);
        for (int i = 0; i < 5; i++) drive(2'b10, (i % 2 == 0) ? 8'hC3 : 8'h3C, 2);
        e.addr = 4'd2; e.data = 8'h3C; e.env = 1'b0; e.cyc = cyc + LAT;
        exp_q.push_back(e);
        drive(2'b10, 8'h3C, 20);
        drive(2'b00, 8'h00, 20);
        check("glitch_r2", reg_of(2), 8'h3C);

        drive(2'b11, 8'h05, 20);
        drive(2'b00, 8'h00, 20);
        drive(2'b10, 8'h12, 3);
        reset_n = 1'b0;
        wait_cyc(1);
        check("midrst_regs", regs, '0);
        check("midrst_outs", {wr_stb, wr_addr, wr_data, env_restart, bus.O_DO_oe}, 0);
        reset_n = 1'b1;
        e.addr = 4'd0; e.data = 8'h12; e.env = 1'b0; e.cyc = cyc + LAT;
        exp_q.push_back(e);
        wait_cyc(20);
        check("postrst_r0", reg_of(0), 8'h12);
        check("postrst_r5", reg_of(5), 8'h00);
        drive(2'b00, 8'h00, 20);

        check("pending_writes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
